instr_fetch: RTL and testbench

- Front-end fetch stage of the RV32I core.
- Owns the program counter, issues word fetches to instruction memory, and holds the fetched instruction in the IF/ID output register.
- Downstream consumers: `if_opcode` drives the control decoder's opcode input; `if_instr`/`if_pc` feed decode and immediate generation.
- Supports pipeline stall and branch/jump redirect, with a one-entry skid buffer so responses are never lost under stall.

---
 rtl/instr_fetch.sv | 123 ++++++++++++
 tb/tb_instr_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, issues single-outstanding word fetches and
// presents the fetched instruction through the IF/ID register with a skid entry.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_opcode,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_resp_pc;
  logic        r_if_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_skid_valid;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic        r_misalign;
  logic        w_accept;
  logic        w_resp;
  logic        w_unused;

  assign w_accept = imem_req & imem_gnt;
  assign w_resp   = (r_state == S_WAIT) & imem_rvalid;
  // JALR semantics: bit 0 of the target never reaches the PC.
  assign w_unused = redirect_target[0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        // A grant coinciding with a redirect leaves a response in flight to drop.
        if (redirect_valid) w_state_nxt = w_accept ? S_DROP : S_REQ;
        else if (w_accept)  w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)         w_state_nxt = S_REQ;
        else if (redirect_valid) w_state_nxt = S_DROP;
      end
      S_DROP: begin
        if (imem_rvalid) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (r_state == S_REQ) && !r_skid_valid;
    imem_addr = r_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_resp_pc    <= RESET_PC;
      r_if_valid   <= 1'b0;
      r_if_pc      <= 32'h0;
      r_if_instr   <= NOP_INSTR;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= 32'h0;
      r_skid_instr <= NOP_INSTR;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign <= redirect_valid & redirect_target[1];
      if (redirect_valid) r_pc <= {redirect_target[31:2], 2'b00};
      else if (w_accept)  r_pc <= r_pc + 32'd4;
      if (w_accept) r_resp_pc <= r_pc;

      if (redirect_valid) begin
        r_if_valid   <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (r_if_valid && stall) begin
        if (w_resp) begin
          r_skid_valid <= 1'b1;
          r_skid_pc    <= r_resp_pc;
          r_skid_instr <= imem_rdata;
        end
      end else if (r_skid_valid) begin
        r_if_valid   <= 1'b1;
        r_if_pc      <= r_skid_pc;
        r_if_instr   <= r_skid_instr;
        r_skid_valid <= 1'b0;
      end else if (w_resp) begin
        r_if_valid <= 1'b1;
        r_if_pc    <= r_resp_pc;
        r_if_instr <= imem_rdata;
      end else begin
        r_if_valid <= 1'b0;
      end
    end
  end

  assign if_valid     = r_if_valid;
  assign if_pc        = r_if_pc;
  assign if_instr     = r_if_instr;
  assign if_opcode    = r_if_instr[6:0];
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus a free-running
// stall sequence that checks every instruction is delivered once and in order.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic        misalign_err;

  int tests = 0;
  int fails = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_opcode(if_opcode), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, stall, redir;
    logic [31:0] tgt;
    bit          gnt, rv;
    logic [31:0] rdata;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_ifv;
    logic [31:0] e_pc, e_instr;
    bit          e_mis;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] f(input logic [31:0] a);
    return ((a << 8) ^ 32'hDEAD_BE00) | {25'd0, a[4:2], 4'b0011};
  endfunction

  task automatic add(input bit r, s, rd, input logic [31:0] tg, input bit g, v,
                     input logic [31:0] d, input bit er, input logic [31:0] ea,
                     input bit eiv, input logic [31:0] ep, ei, input bit em);
    vec_t x;
    x.rst = r; x.stall = s; x.redir = rd; x.tgt = tg; x.gnt = g; x.rv = v;
    x.rdata = d; x.e_req = er; x.e_addr = ea; x.e_ifv = eiv; x.e_pc = ep;
    x.e_instr = ei; x.e_mis = em;
    vq.push_back(x);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %h, required %h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [31:0] nop;
    logic [6:0]  eop;
    bit          pend;
    logic [31:0] pend_addr, exp_pc, cpc, cinstr, aaddr;
    bit          cons, acc;
    int          ncons;
    nop = 32'h0000_0013;

    //  rst s rd tgt          g v rdata           req addr          ifv pc            instr           mis
    add(1, 0, 0, 32'h0,       0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         nop,            0); // 0 reset
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,          1, 32'h0,         0, 32'h0,         nop,            0); // 1 idle->req
    add(0, 0, 0, 32'h0,       1, 0, 32'h0,          0, 32'h4,         0, 32'h0,         nop,            0); // 2
    add(0, 0, 0, 32'h0,       0, 1, f(32'h0),       1, 32'h4,         1, 32'h0,         f(32'h0),       0); // 3
    add(0, 0, 0, 32'h0,       1, 0, 32'h0,          0, 32'h8,         0, 32'h0,         f(32'h0),       0); // 4
    add(0, 0, 0, 32'h0,       0, 1, f(32'h4),       1, 32'h8,         1, 32'h4,         f(32'h4),       0); // 5
    add(0, 0, 0, 32'h0,       1, 0, 32'h0,          0, 32'hC,         0, 32'h4,         f(32'h4),       0); // 6
    add(0, 0, 0, 32'h0,       0, 1, f(32'h8),       1, 32'hC,         1, 32'h8,         f(32'h8),       0); // 7
    add(0, 1, 0, 32'h0,       1, 0, 32'h0,          0, 32'h10,        1, 32'h8,         f(32'h8),       0); // 8 stall
    add(0, 1, 0, 32'h0,       0, 1, f(32'hC),       0, 32'h10,        1, 32'h8,         f(32'h8),       0); // 9 to skid
    add(0, 1, 0, 32'h0,       1, 0, 32'h0,          0, 32'h10,        1, 32'h8,         f(32'h8),       0); // 10
    add(0, 1, 0, 32'h0,       1, 0, 32'h0,          0, 32'h10,        1, 32'h8,         f(32'h8),       0); // 11
    add(0, 1, 0, 32'h0,       0, 0, 32'h0,          0, 32'h10,        1, 32'h8,         f(32'h8),       0); // 12
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,          1, 32'h10,        1, 32'hC,         f(32'hC),       0); // 13 skid out
    add(0, 0, 0, 32'h0,       1, 0, 32'h0,          0, 32'h14,        0, 32'hC,         f(32'hC),       0); // 14
    add(0, 0, 0, 32'h0,       0, 1, f(32'h10),      1, 32'h14,        1, 32'h10,        f(32'h10),      0); // 15
    add(0, 0, 0, 32'h0,       1, 0, 32'h0,          0, 32'h18,        0, 32'h10,        f(32'h10),      0); // 16
    add(0, 0, 1, 32'h100,     0, 0, 32'h0,          0, 32'h100,       0, 32'h10,        f(32'h10),      0); // 17 redirect in wait
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,          0, 32'h100,       0, 32'h10,        f(32'h10),      0); // 18 drop
    add(0, 0, 0, 32'h0,       0, 1, f(32'h14),      1, 32'h100,       0, 32'h10,        f(32'h10),      0); // 19 discarded
    add(0, 0, 0, 32'h0,       1, 0, 32'h0,          0, 32'h104,       0, 32'h10,        f(32'h10),      0); // 20
    add(0, 0, 0, 32'h0,       0, 1, f(32'h100),     1, 32'h104,       1, 32'h100,       f(32'h100),     0); // 21
    add(0, 1, 0, 32'h0,       1, 0, 32'h0,          0, 32'h108,       1, 32'h100,       f(32'h100),     0); // 22
    add(0, 1, 1, 32'h200,     0, 1, f(32'h104),     1, 32'h200,       0, 32'h100,       f(32'h100),     0); // 23 redir+rv+stall
    add(0, 0, 0, 32'h0,       1, 0, 32'h0,          0, 32'h204,       0, 32'h100,       f(32'h100),     0); // 24
    add(0, 0, 0, 32'h0,       0, 1, f(32'h200),     1, 32'h204,       1, 32'h200,       f(32'h200),     0); // 25
    add(0, 0, 1, 32'h206,     0, 0, 32'h0,          1, 32'h204,       0, 32'h200,       f(32'h200),     1); // 26 misaligned
    add(0, 0, 0, 32'h0,       0, 0, 32'h0,          1, 32'h204,       0, 32'h200,       f(32'h200),     0); // 27
    add(0, 0, 1, 32'h300,     1, 0, 32'h0,          0, 32'h300,       0, 32'h200,       f(32'h200),     0); // 28 grant+redirect
    add(0, 0, 0, 32'h0,       0, 1, f(32'h204),     1, 32'h300,       0, 32'h200,       f(32'h200),     0); // 29
    add(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h200,       f(32'h200),     0); // 30
    add(0, 0, 0, 32'h0,       1, 0, 32'h0,          0, 32'h0,         0, 32'h200,       f(32'h200),     0); // 31 wrap
    add(0, 0, 0, 32'h0,       0, 1, f(32'hFFFF_FFFC), 1, 32'h0,       1, 32'hFFFF_FFFC, f(32'hFFFF_FFFC), 0); // 32
    add(0, 0, 0, 32'h0,       1, 0, 32'h0,          0, 32'h4,         0, 32'hFFFF_FFFC, f(32'hFFFF_FFFC), 0); // 33
    add(1, 0, 0, 32'h0,       0, 0, 32'h0,          0, 32'h0,         0, 32'h0,         nop,            0); // 34 rst in wait
    add(0, 0, 0, 32'h0,       0, 1, 32'h1234_5678,  1, 32'h0,         0, 32'h0,         nop,            0); // 35 late rvalid

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; stall = vq[i].stall; redirect_valid = vq[i].redir;
      redirect_target = vq[i].tgt; imem_gnt = vq[i].gnt;
      imem_rvalid = vq[i].rv; imem_rdata = vq[i].rdata;
      @(posedge clk);
      #1;
      eop = vq[i].e_instr[6:0];
      check("imem_req", i, {31'd0, imem_req}, {31'd0, vq[i].e_req});
      check("imem_addr", i, imem_addr, vq[i].e_addr);
      check("if_valid", i, {31'd0, if_valid}, {31'd0, vq[i].e_ifv});
      check("if_pc", i, if_pc, vq[i].e_pc);
      check("if_instr", i, if_instr, vq[i].e_instr);
      check("if_opcode", i, {25'd0, if_opcode}, {25'd0, eop});
      check("misalign_err", i, {31'd0, misalign_err}, {31'd0, vq[i].e_mis});
    end

    // Free-running stream with periodic stall: delivery must be in order, no gaps.
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pend = 1'b0; pend_addr = 32'h0; exp_pc = 32'h0; ncons = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      stall       = (c % 4 == 1) || (c % 4 == 2);
      imem_gnt    = 1'b1;
      imem_rvalid = pend;
      imem_rdata  = f(pend_addr);
      cons   = if_valid && !stall;
      cpc    = if_pc;
      cinstr = if_instr;
      acc    = imem_req;
      aaddr  = imem_addr;
      @(posedge clk);
      if (cons) begin
        check("stream_pc", ncons, cpc, exp_pc);
        check("stream_instr", ncons, cinstr, f(exp_pc));
        exp_pc = exp_pc + 32'd4;
        ncons++;
      end
      if (imem_rvalid) pend = 1'b0;
      if (acc) begin
        pend = 1'b1;
        pend_addr = aaddr;
      end
    end
    check("stream_count_ge20", 0, {31'd0, ncons >= 20}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
